// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write-back and decode signals between the pipeline and the
// register file.
//   master: pipeline side; drives write-back, read addresses and load issue,
//           receives read data and stall.
//   slave : register file side.
interface regfile_sb_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic [AW-1:0]   WB_reg_write_address_i;
  logic [XLEN-1:0] WB_reg_write_data_i;
  logic            WB_ctrl_reg_write_i;
  logic [AW-1:0]   ID_rs_address_i;
  logic [AW-1:0]   ID_rt_address_i;
  logic [XLEN-1:0] ID_rs_data_o;
  logic [XLEN-1:0] ID_rt_data_o;
  logic            ID_load_issue_i;
  logic [AW-1:0]   ID_load_rd_i;
  logic            ID_stall_o;

  modport master (
    output WB_reg_write_address_i, WB_reg_write_data_i, WB_ctrl_reg_write_i,
    output ID_rs_address_i, ID_rt_address_i, ID_load_issue_i, ID_load_rd_i,
    input  ID_rs_data_o, ID_rt_data_o, ID_stall_o
  );

  modport slave (
    input  WB_reg_write_address_i, WB_reg_write_data_i, WB_ctrl_reg_write_i,
    input  ID_rs_address_i, ID_rt_address_i, ID_load_issue_i, ID_load_rd_i,
    output ID_rs_data_o, ID_rt_data_o, ID_stall_o
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x 32-bit architectural register file with a load-use
// scoreboard for the decode stage.
//   clk_i   : clock, all state changes on the rising edge
//   n_rst_i : synchronous active-low reset (clears registers and busy bits)
//   bus     : regfile_sb_if.slave -- write-back port, two combinational read
//             ports, load issue and combinational decode stall.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding of
// the write-back data onto matching read ports, with stall relief.
module regfile_sb (
  input  logic         clk_i,
  input  logic         n_rst_i,
  regfile_sb_if.slave  bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            wb_we_c;
  logic            rs_fwd_c;
  logic            rt_fwd_c;
  logic            rs_wait_c;
  logic            rt_wait_c;
  logic            stall_c;

  // A write to r0 is a no-op for both storage and forwarding.
  assign wb_we_c = bus.WB_ctrl_reg_write_i && (bus.WB_reg_write_address_i != AW'(0));

  // Forwarding hits: a read port matching the in-flight write-back.
  always_comb begin
    rs_fwd_c = 1'b0;
    rt_fwd_c = 1'b0;
`ifdef REGFILE_BYPASS_EN
    rs_fwd_c = wb_we_c && (bus.WB_reg_write_address_i == bus.ID_rs_address_i);
    rt_fwd_c = wb_we_c && (bus.WB_reg_write_address_i == bus.ID_rt_address_i);
`endif
  end

  // Read ports: r0 is hard zero, forwarded data beats array contents.
  always_comb begin
    bus.ID_rs_data_o = regs_q[bus.ID_rs_address_i];
    bus.ID_rt_data_o = regs_q[bus.ID_rt_address_i];
    if (rs_fwd_c) bus.ID_rs_data_o = bus.WB_reg_write_data_i;
    if (rt_fwd_c) bus.ID_rt_data_o = bus.WB_reg_write_data_i;
    if (bus.ID_rs_address_i == AW'(0)) bus.ID_rs_data_o = XLEN'(0);
    if (bus.ID_rt_address_i == AW'(0)) bus.ID_rt_data_o = XLEN'(0);
  end

  // Stall: a busy operand that is not being delivered this cycle.
  always_comb begin
    rs_wait_c = busy_q[bus.ID_rs_address_i] && (bus.ID_rs_address_i != AW'(0)) && !rs_fwd_c;
    rt_wait_c = busy_q[bus.ID_rt_address_i] && (bus.ID_rt_address_i != AW'(0)) && !rt_fwd_c;
    stall_c   = rs_wait_c || rt_wait_c;
  end

  assign bus.ID_stall_o = stall_c;

  // Scoreboard next state: clear on write-back, then set on an accepted
  // issue so a younger load to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.WB_ctrl_reg_write_i) begin
      busy_d[bus.WB_reg_write_address_i] = 1'b0;
    end
    if (bus.ID_load_issue_i && !stall_c && (bus.ID_load_rd_i != AW'(0))) begin
      busy_d[bus.ID_load_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register array; r0 is only ever written by reset.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= XLEN'(0);
      end
    end else if (wb_we_c) begin
      regs_q[bus.WB_reg_write_address_i] <= bus.WB_reg_write_data_i;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk_i   = 1'b0;
  logic n_rst_i = 1'b0;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  bit   [31:0] m_busy;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && bus.WB_ctrl_reg_write_i && bus.WB_reg_write_address_i == a)
      return bus.WB_reg_write_data_i;
    return m_regs[a];
  endfunction

  function automatic bit port_waits(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (!m_busy[a]) return 1'b0;
    if (BYP && bus.WB_ctrl_reg_write_i && bus.WB_reg_write_address_i == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    return port_waits(bus.ID_rs_address_i) || port_waits(bus.ID_rt_address_i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update on each rising edge, using pre-edge inputs.
  always @(posedge clk_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_busy = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit st;
      st = exp_stall();
      if (bus.WB_ctrl_reg_write_i && bus.WB_reg_write_address_i != 5'd0)
        m_regs[bus.WB_reg_write_address_i] = bus.WB_reg_write_data_i;
      if (bus.WB_ctrl_reg_write_i) m_busy[bus.WB_reg_write_address_i] = 1'b0;
      if (bus.ID_load_issue_i && !st && bus.ID_load_rd_i != 5'd0)
        m_busy[bus.ID_load_rd_i] = 1'b1;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (model_valid) begin
      check("rs_data", bus.ID_rs_data_o, exp_read(bus.ID_rs_address_i));
      check("rt_data", bus.ID_rt_data_o, exp_read(bus.ID_rt_address_i));
      check("stall", 32'(bus.ID_stall_o), 32'(exp_stall()));
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.WB_ctrl_reg_write_i    = 1'b0;
    bus.WB_reg_write_address_i = 5'd0;
    bus.WB_reg_write_data_i    = 32'h0;
    bus.ID_load_issue_i        = 1'b0;
    bus.ID_load_rd_i           = 5'd0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.WB_ctrl_reg_write_i    = 1'b1;
    bus.WB_reg_write_address_i = a;
    bus.WB_reg_write_data_i    = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.ID_load_issue_i = 1'b1;
    bus.ID_load_rd_i    = rd;
  endtask

  initial begin
    idle();
    bus.ID_rs_address_i = 5'd5;
    bus.ID_rt_address_i = 5'd0;
    // Reset with a write of r5 requested; reset must override it.
    wb(5'd5, 32'hDEADBEEF);
    next_cycle();
    next_cycle();
    n_rst_i = 1'b1;
    idle();
    @(negedge clk_i);
    check("reset_r5", bus.ID_rs_data_o, 32'h0);
    check("reset_stall", 32'(bus.ID_stall_o), 32'h0);

    // Write then read r7.
    next_cycle();
    wb(5'd7, 32'h12345678);
    bus.ID_rs_address_i = 5'd7;
    @(negedge clk_i);
    check("wr_cycle_r7", bus.ID_rs_data_o, BYP ? 32'h12345678 : 32'h0);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("after_wr_r7", bus.ID_rs_data_o, 32'h12345678);

    // Register 0 is hard zero and never stalls.
    next_cycle();
    wb(5'd0, 32'hFFFFFFFF);
    bus.ID_rs_address_i = 5'd0;
    bus.ID_rt_address_i = 5'd0;
    next_cycle();
    idle();
    issue(5'd0);
    @(negedge clk_i);
    check("r0_rs", bus.ID_rs_data_o, 32'h0);
    check("r0_rt", bus.ID_rt_data_o, 32'h0);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("r0_no_stall", 32'(bus.ID_stall_o), 32'h0);

    // Load-use stall on r3.
    issue(5'd3);
    next_cycle();
    idle();
    bus.ID_rt_address_i = 5'd3;
    @(negedge clk_i);
    check("lu_stall1", 32'(bus.ID_stall_o), 32'h1);
    next_cycle();
    @(negedge clk_i);
    check("lu_stall2", 32'(bus.ID_stall_o), 32'h1);
    next_cycle();
    wb(5'd3, 32'hA5A5A5A5);
    @(negedge clk_i);
    check("lu_wb_stall", 32'(bus.ID_stall_o), BYP ? 32'h0 : 32'h1);
    check("lu_wb_data", bus.ID_rt_data_o, BYP ? 32'hA5A5A5A5 : 32'h0);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("lu_after_stall", 32'(bus.ID_stall_o), 32'h0);
    check("lu_after_data", bus.ID_rt_data_o, 32'hA5A5A5A5);

    // Simultaneous set and clear of r4: set wins.
    bus.ID_rt_address_i = 5'd0;
    bus.ID_rs_address_i = 5'd0;
    wb(5'd4, 32'h11111111);
    issue(5'd4);
    next_cycle();
    idle();
    bus.ID_rs_address_i = 5'd4;
    @(negedge clk_i);
    check("sc_stall", 32'(bus.ID_stall_o), 32'h1);
    check("sc_data", bus.ID_rs_data_o, 32'h11111111);
    next_cycle();
    @(negedge clk_i);
    check("sc_stall_hold", 32'(bus.ID_stall_o), 32'h1);
    next_cycle();
    wb(5'd4, 32'h22222222);
    @(negedge clk_i);
    check("sc_wb_stall", 32'(bus.ID_stall_o), BYP ? 32'h0 : 32'h1);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("sc_release", 32'(bus.ID_stall_o), 32'h0);

    // Issue while stalled is ignored.
    bus.ID_rs_address_i = 5'd0;
    issue(5'd2);
    next_cycle();
    idle();
    bus.ID_rs_address_i = 5'd2;
    issue(5'd9);
    @(negedge clk_i);
    check("si_stalled", 32'(bus.ID_stall_o), 32'h1);
    next_cycle();
    idle();
    wb(5'd2, 32'h00000005);
    next_cycle();
    idle();
    bus.ID_rs_address_i = 5'd9;
    @(negedge clk_i);
    check("si_r9_free", 32'(bus.ID_stall_o), 32'h0);

    // Randomized traffic, addresses biased to a small range to force hits.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      n_rst_i = ($urandom_range(0, 99) != 0);
      bus.WB_ctrl_reg_write_i    = ($urandom_range(0, 1) == 1);
      bus.WB_reg_write_address_i = 5'($urandom_range(0, 7));
      bus.WB_reg_write_data_i    = $urandom;
      bus.ID_rs_address_i        = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.ID_rt_address_i        = 5'($urandom_range(0, 7));
      bus.ID_load_issue_i        = ($urandom_range(0, 2) == 0);
      bus.ID_load_rd_i           = 5'($urandom_range(0, 7));
    end
    next_cycle();
    n_rst_i = 1'b1;
    idle();
    next_cycle();
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Architectural register file: the receiving end of the write-back interface, with a load-use scoreboard for the decode stage. Holds 32 × 32-bit general registers and accepts one write per cycle from write-back. Serves two combinational read ports to the decode stage. Tracks registers with an outstanding load and raises a decode stall when an operand is not yet available.

## Interface
- `NREG`, 32, number of architectural registers; the address width is 5 bits.
- `XLEN`, 32, register data width.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `n_rst_i`  in  1  synchronous, active-low reset.
- `WB_reg_write_address_i`  in  5  destination register from write-back.
- `WB_reg_write_data_i`  in  32  write data from write-back.
- `WB_ctrl_reg_write_i`  in  1  write enable from write-back.
- `ID_rs_address_i`  in  5  read port A address.
- `ID_rt_address_i`  in  5  read port B address.
- `ID_rs_data_o`  out  32  read port A data, combinational.
- `ID_rt_data_o`  out  32  read port B data, combinational.
- `ID_load_issue_i`  in  1  decode issues a load this cycle.
- `ID_load_rd_i`  in  5  destination register of the issued load.
- `ID_stall_o`  out  1  operand not available; decode must hold.

## Operation
- **Storage:** 32 × 32-bit array. Register 0 reads as 0 at all times. Writes to register 0 are discarded.
- **Write:** on a clock edge with `WB_ctrl_reg_write_i` = 1 and address ≠ 0, the array entry takes `WB_reg_write_data_i`.
- **Read:** each port returns the array entry for its address. Register 0 returns 0.
- **Scoreboard:** one busy bit per register. Bit 0 is always 0.
  - **Set:** on an edge with `ID_load_issue_i` = 1, `ID_stall_o` = 0 and `ID_load_rd_i` ≠ 0, set `busy[ID_load_rd_i]`.
  - **Ignored issue:** an issue while `ID_stall_o` = 1 is ignored.
  - **Clear:** on an edge with `WB_ctrl_reg_write_i` = 1, clear `busy[WB_reg_write_address_i]`.
  - **Simultaneous set and clear of the same register:** set wins, because the new load is younger.
- **Stall:** `ID_stall_o` = 1 when `busy[ID_rs_address_i]` or `busy[ID_rt_address_i]` is set, subject to the bypass relief under Configuration. Address 0 never stalls.
- **Reset:** an edge with `n_rst_i` = 0 has the following effects.
  - All 32 registers are cleared to 0.
  - All busy bits are cleared.
  - Resulting outputs: `ID_stall_o` = 0, and both read ports = 0 for any address.
  - Reset overrides any write or issue in the same cycle.
  - Reset asserted mid-operation discards all pending loads.

## Timing
- Write latency: 1 edge. Data written at edge N is visible on the read ports from just after edge N, or in the same cycle when bypass is enabled.
- Read latency: 0. The read ports are pure combinational functions of address, array and bypass.
- Scoreboard set at edge N: `ID_stall_o` for a consumer of that register is 1 from just after edge N.
- Scoreboard clear at edge N: stall drops just after edge N, or during the write cycle when bypass is enabled.
- `ID_stall_o` has no registered delay. It is a combinational function of the addresses, busy bits and write-back inputs.
- One write per cycle and one issue per cycle. There are no queues and no overflow condition: 32 busy bits cover every register.

## Configuration
- **`REGFILE_BYPASS_EN` defined:**
  - Write-through forwarding. When `WB_ctrl_reg_write_i` = 1, the write address ≠ 0 and it equals a read address, that read port returns `WB_reg_write_data_i` in the same cycle.
  - The stall term for that port is suppressed in that cycle, because the data is available now.
- **`REGFILE_BYPASS_EN` undefined:**
  - Reads always return array contents, so a same-cycle write is visible only after the edge.
  - A busy operand stalls through the write-back cycle and releases one cycle later.

## Test plan
- **Reset:** hold `n_rst_i` = 0 for 2 cycles, with a write of 0xDEADBEEF to r5 requested during reset.
  - After release, rs = 5 reads 0 and `ID_stall_o` = 0.
- **Write then read:** write r7 = 0x12345678.
  - With bypass, rs = 7 reads 0x12345678 in the write cycle.
  - Without bypass, it reads 0x12345678 from the next cycle.
- **Register 0:** write r0 = 0xFFFFFFFF, then read rs = rt = 0.
  - Both ports return 0 and no stall occurs.
  - Issue a load to r0; there is still no stall.
- **Load-use stall:** issue a load to r3; next cycle rt = 3.
  - `ID_stall_o` = 1 until write-back writes r3 = 0xA5A5A5A5.
  - With bypass, the stall drops in the write cycle and rt reads 0xA5A5A5A5.
  - Without bypass, the stall drops and the value appears one cycle later.
- **Simultaneous set and clear:** write-back writes r4 while a load to r4 issues in the same edge.
  - `busy[4]` remains 1 and a reader of r4 stalls until the next write of r4.
- **Stalled issue ignored:** set r2 busy and hold rs = 2 so stall = 1, then assert an issue to r9.
  - After write-back clears r2, rs = 9 does not stall, because `busy[9]` was never set.
